// File: rtl/clksel_if.sv
// Handshake bundle between the clock-switch sequencer, its requester and the HS clock domains.
// The sequencer takes the slave modport; the requester/clock-domain side takes master.
interface clksel_if #(
  parameter int NUM_HS = 2,
  parameter int DIV_W  = 2,
  parameter int SRC_W  = $clog2(NUM_HS + 1)
);
  logic              req_valid;
  logic [SRC_W-1:0]  req_src;
  logic [DIV_W-1:0]  req_div;
  logic              req_ready;
  logic [NUM_HS-1:0] hs_en_ack;
  logic [NUM_HS-1:0] hs_en_req;
  logic              ls_en;
  logic [DIV_W-1:0]  div_sel;
  logic [SRC_W-1:0]  cur_src;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_src, req_div, hs_en_ack,
    input  req_ready, hs_en_req, ls_en, div_sel, cur_src, done, err
  );

  modport slave (
    input  req_valid, req_src, req_div, hs_en_ack,
    output req_ready, hs_en_req, ls_en, div_sel, cur_src, done, err
  );
endinterface

// File: rtl/clksel_seq.sv
// Glitch-free clock source switch sequencer running on the low-speed clock: drops the old
// source, dwells with every enable off, then raises the new source and waits for its ack.
module clksel_seq #(
  parameter int NUM_HS         = 2,
  parameter int DIV_W          = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int DWELL_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int SRC_W         = $clog2(NUM_HS + 1)
) (
  input  logic     lsclk_in,
  input  logic     rst_b,
  clksel_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DROP, DWELL, RAISE} state_t;

  localparam int CNT_MAX = (TIMEOUT_CYCLES > DWELL_CYCLES) ? TIMEOUT_CYCLES : DWELL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t                             state_q, state_d;
  logic [SYNC_STAGES-1:0][NUM_HS-1:0] sync_q, sync_d;
  logic [SRC_W-1:0]                   tgt_src_q, tgt_src_d;
  logic [SRC_W-1:0]                   old_src_q, old_src_d;
  logic [SRC_W-1:0]                   cur_src_q, cur_src_d;
  logic [DIV_W-1:0]                   tgt_div_q, tgt_div_d;
  logic [DIV_W-1:0]                   div_sel_q, div_sel_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               ls_en_q, ls_en_d;
  logic [NUM_HS-1:0]                  hs_en_req_q, hs_en_req_d;
  logic                               req_ready_q, req_ready_d;
  logic                               done_q, done_d;
  logic                               err_q, err_d;

  logic [NUM_HS-1:0]                  sack;
  logic [NUM_HS-1:0]                  tgt_onehot;
  logic                               old_ack;
  logic                               tgt_ack;
  logic                               accept;
  logic                               req_bad;
  logic                               req_same;

  // Acks come from unrelated clock domains, so each bit crosses a plain flop chain.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = bus.hs_en_ack;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sack = sync_q[SYNC_STAGES-1];

  always_comb begin
    old_ack    = 1'b0;
    tgt_ack    = 1'b0;
    tgt_onehot = '0;
    for (int k = 0; k < NUM_HS; k++) begin
      if (old_src_q == SRC_W'(k + 1)) begin
        old_ack = sack[k];
      end
      if (tgt_src_q == SRC_W'(k + 1)) begin
        tgt_ack       = sack[k];
        tgt_onehot[k] = 1'b1;
      end
    end
  end

  assign accept   = bus.req_valid & req_ready_q;
  assign req_bad  = bus.req_src > SRC_W'(NUM_HS);
  assign req_same = (bus.req_src == cur_src_q) && (bus.req_div == div_sel_q);

  always_comb begin
    state_d     = state_q;
    tgt_src_d   = tgt_src_q;
    old_src_d   = old_src_q;
    cur_src_d   = cur_src_q;
    tgt_div_d   = tgt_div_q;
    div_sel_d   = div_sel_q;
    cnt_d       = cnt_q;
    ls_en_d     = ls_en_q;
    hs_en_req_d = hs_en_req_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else if (req_same) begin
            done_d = 1'b1;
          end else begin
            tgt_src_d   = bus.req_src;
            tgt_div_d   = bus.req_div;
            old_src_d   = cur_src_q;
            ls_en_d     = 1'b0;
            hs_en_req_d = '0;
            state_d     = DROP;
          end
        end
      end

      // LS enable is local, so only an HS source needs its ack to fall before moving on.
      DROP: begin
        if ((old_src_q == '0) || !old_ack) begin
          div_sel_d = tgt_div_q;
          cnt_d     = '0;
          state_d   = DWELL;
        end
      end

      DWELL: begin
        if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
          ls_en_d     = (tgt_src_q == '0);
          hs_en_req_d = tgt_onehot;
          cnt_d       = '0;
          state_d     = RAISE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // A source that never acks is abandoned and the sequence falls back to LS, div 0.
      RAISE: begin
        if ((tgt_src_q == '0) || tgt_ack) begin
          cur_src_d = tgt_src_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          hs_en_req_d = '0;
          err_d       = 1'b1;
          old_src_d   = tgt_src_q;
          tgt_src_d   = '0;
          tgt_div_d   = '0;
          cnt_d       = '0;
          state_d     = DROP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge lsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      tgt_src_q   <= '0;
      old_src_q   <= '0;
      cur_src_q   <= '0;
      tgt_div_q   <= '0;
      div_sel_q   <= '0;
      cnt_q       <= '0;
      ls_en_q     <= 1'b1;
      hs_en_req_q <= '0;
      req_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      tgt_src_q   <= tgt_src_d;
      old_src_q   <= old_src_d;
      cur_src_q   <= cur_src_d;
      tgt_div_q   <= tgt_div_d;
      div_sel_q   <= div_sel_d;
      cnt_q       <= cnt_d;
      ls_en_q     <= ls_en_d;
      hs_en_req_q <= hs_en_req_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.hs_en_req = hs_en_req_q;
  assign bus.ls_en     = ls_en_q;
  assign bus.div_sel   = div_sel_q;
  assign bus.cur_src   = cur_src_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  a_no_overlap: assert property (@(posedge lsclk_in) disable iff (!rst_b)
    $onehot0({ls_en_q, hs_en_req_q}));

  a_done_err_excl: assert property (@(posedge lsclk_in) disable iff (!rst_b)
    !(done_q && err_q));

endmodule

// File: tb/tb_clksel_seq.sv
// Randomized bench for clksel_seq: a transaction-level model predicts each switch's phase
// boundaries from source ack latencies and checks every output on every cycle.
module tb_clksel_seq;

  localparam int NUM_HS         = 2;
  localparam int DIV_W          = 2;
  localparam int SYNC_STAGES    = 2;
  localparam int DWELL_CYCLES   = 4;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int SRC_W          = $clog2(NUM_HS + 1);

  logic lsclk_in = 1'b0;
  logic rst_b    = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int model_src = 0;
  int model_div = 0;

  logic [3:0]        lat [NUM_HS];
  logic [15:0]       hist [NUM_HS] = '{default: '0};
  logic [NUM_HS-1:0] stuck = '0;

  clksel_if #(.NUM_HS(NUM_HS), .DIV_W(DIV_W)) bus ();

  clksel_seq #(
    .NUM_HS(NUM_HS), .DIV_W(DIV_W), .SYNC_STAGES(SYNC_STAGES),
    .DWELL_CYCLES(DWELL_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .lsclk_in(lsclk_in),
    .rst_b(rst_b),
    .bus(bus)
  );

  always #5 lsclk_in = ~lsclk_in;

  // Each HS domain echoes its enable request lat[k] cycles later, unless it is stuck.
  always @(negedge lsclk_in) begin
    logic [NUM_HS-1:0] ack;
    ack = '0;
    for (int k = 0; k < NUM_HS; k++) begin
      hist[k] = {hist[k][14:0], bus.hs_en_req[k]};
      ack[k]  = !stuck[k] && hist[k][lat[k]];
    end
    bus.hs_en_ack = ack;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obsVec();
    return 32'({bus.req_ready, bus.done, bus.err, bus.ls_en, bus.hs_en_req, bus.div_sel, bus.cur_src});
  endfunction

  // en: -1 = no enable, 0 = LS, k = HS source k
  function automatic logic [31:0] expVec(input bit rr, input bit dn, input bit er,
                                         input int en, input int dv, input int cs);
    logic [NUM_HS-1:0] hs;
    hs = '0;
    for (int k = 0; k < NUM_HS; k++) begin
      if (en == k + 1) hs[k] = 1'b1;
    end
    return 32'({rr, dn, er, (en == 0), hs, DIV_W'(dv), SRC_W'(cs)});
  endfunction

  function automatic int dropCycles(input int old_src);
    return (old_src == 0) ? 1 : int'(lat[old_src-1]) + SYNC_STAGES + 1;
  endfunction

  task automatic applyStimulus(input int src, input int div, input bit stuck_tgt);
    int old_src, old_div, w, r, d, e, w2, r2, fin_src, fin_div, en, dv;
    bit invalid, same, tmo;
    old_src = model_src;
    old_div = model_div;
    invalid = (src > NUM_HS);
    same    = !invalid && (src == old_src) && (div == old_div);
    tmo     = stuck_tgt && !invalid && !same && (src != 0) && (src != old_src);

    @(negedge lsclk_in);
    stuck = '0;
    if (tmo) stuck[src-1] = 1'b1;
    @(negedge lsclk_in);
    checkOutput("idle", obsVec(), expVec(1, 0, 0, old_src, old_div, old_src));
    bus.req_valid = 1'b1;
    bus.req_src   = SRC_W'(src);
    bus.req_div   = DIV_W'(div);
    @(negedge lsclk_in);
    bus.req_valid = 1'b0;

    if (invalid || same) begin
      checkOutput(invalid ? "err_pulse" : "same_done", obsVec(),
                  expVec(1, same, invalid, old_src, old_div, old_src));
      @(negedge lsclk_in);
      checkOutput("after_pulse", obsVec(), expVec(1, 0, 0, old_src, old_div, old_src));
      return;
    end

    w  = dropCycles(old_src);
    r  = w + DWELL_CYCLES;
    e  = r + TIMEOUT_CYCLES;
    w2 = e + 1;
    r2 = w2 + DWELL_CYCLES;
    if (tmo) begin
      d = r2 + 1;
      fin_src = 0;
      fin_div = 0;
    end else begin
      d = (src == 0) ? r + 1 : r + int'(lat[src-1]) + SYNC_STAGES + 1;
      fin_src = src;
      fin_div = div;
    end

    for (int i = 0; i <= d + 1; i++) begin
      en = -1;
      if (!tmo && i >= r) en = src;
      if (tmo && i >= r && i < e) en = src;
      if (tmo && i >= r2) en = 0;
      dv = (i < w) ? old_div : (tmo && i >= w2) ? 0 : div;
      checkOutput($sformatf("sw_%0d_to_%0d_cyc%0d", old_src, src, i), obsVec(),
                  expVec(i >= d, i == d, tmo && i == e, en, dv, (i >= d) ? fin_src : old_src));
      // Requests arriving mid-switch must be ignored.
      if (i + 2 <= d) begin
        bus.req_valid = ($urandom_range(0, 3) == 0);
        bus.req_src   = SRC_W'($urandom_range(0, NUM_HS + 1));
        bus.req_div   = DIV_W'($urandom_range(0, (1 << DIV_W) - 1));
      end else begin
        bus.req_valid = 1'b0;
      end
      @(negedge lsclk_in);
    end
    model_src = fin_src;
    model_div = fin_div;
  endtask

  task automatic resetInDwell(input int src, input int div);
    int w;
    w = dropCycles(model_src);
    @(negedge lsclk_in);
    stuck = '0;
    bus.req_valid = 1'b1;
    bus.req_src   = SRC_W'(src);
    bus.req_div   = DIV_W'(div);
    @(negedge lsclk_in);
    bus.req_valid = 1'b0;
    for (int i = 0; i < w + 1; i++) @(negedge lsclk_in);
    checkOutput("in_dwell", obsVec(), expVec(0, 0, 0, -1, div, model_src));
    rst_b = 1'b0;
    #1;
    checkOutput("rst_async", obsVec(), expVec(1, 0, 0, 0, 0, 0));
    @(negedge lsclk_in);
    rst_b = 1'b1;
    @(negedge lsclk_in);
    checkOutput("rst_release", obsVec(), expVec(1, 0, 0, 0, 0, 0));
    model_src = 0;
    model_div = 0;
    for (int i = 0; i < 8; i++) @(negedge lsclk_in);
  endtask

  initial begin
    int src, div;
    bit stk;
    bus.req_valid = 1'b0;
    bus.req_src   = '0;
    bus.req_div   = '0;
    lat[0] = 4'd1;
    for (int k = 1; k < NUM_HS; k++) lat[k] = 4'($urandom_range(0, 4));

    rst_b = 1'b0;
    repeat (3) @(negedge lsclk_in);
    checkOutput("reset_state", obsVec(), expVec(1, 0, 0, 0, 0, 0));
    rst_b = 1'b1;
    @(negedge lsclk_in);
    checkOutput("after_reset", obsVec(), expVec(1, 0, 0, 0, 0, 0));

    applyStimulus(1, 2, 1'b0);
    applyStimulus(3, 0, 1'b0);
    applyStimulus(1, 2, 1'b0);
    applyStimulus(2, 1, 1'b0);
    applyStimulus(1, 3, 1'b0);
    applyStimulus(2, 1, 1'b1);
    applyStimulus(0, 2, 1'b0);
    resetInDwell(2, 3);

    for (int n = 0; n < 24; n++) begin
      src = $urandom_range(0, NUM_HS + 1);
      div = $urandom_range(0, (1 << DIV_W) - 1);
      stk = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) begin
        src = model_src;
        div = model_div;
      end
      applyStimulus(src, div, stk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
